canny_frame_sequencer: RTL
==========================

# canny_frame_sequencer

Frame-level controller for the Canny edge-detection pipeline. It sits between the AXI-Stream pixel source and the first line-buffer stage (gaussian input), and also watches the output-FIFO master handshake. It gates input under FIFO back-pressure and counts pixels, lines and frames. At end of frame it injects zero-valued flush lines so the five cascaded 3-line buffers empty. It then tracks the output pixel count, marks the last output beat with `o_out_last` and signals frame completion.

## Interface
- `IMG_WIDTH`, 512, pixels per line
- `IMG_HEIGHT`, 512, lines per input frame
- `FLUSH_LINES`, 10, zero lines injected after the frame
- `OUT_PIXELS`, 262144, expected output beats per frame
- `TIMEOUT_CYCLES`, 65535, drain watchdog limit (used only with macro)

- `i_clk` in 1: clock; single clock domain
- `i_rst` in 1: asynchronous, active-high reset
- `i_start` in 1: start-of-frame pulse
- `s_valid` in 1: source pixel valid
- `s_data` in 8: source pixel
- `s_ready` out 1: source ready
- `o_pix_valid` out 1: pixel to pipeline valid
- `o_pix_data` out 8: pixel to pipeline
- `i_pipe_full` in 1: output FIFO prog_full
- `i_out_valid` in 1: output FIFO m_axis_tvalid
- `i_out_ready` in 1: output FIFO m_axis_tready
- `o_out_last` out 1: last output beat marker
- `o_busy` out 1: frame in progress
- `o_intr` out 1: one-cycle pulse per accepted input line
- `o_frame_done` out 1: one-cycle completion pulse
- `o_overrun` out 1: sticky, output beat seen with no frame pending
- `o_timeout` out 1: sticky watchdog flag

## Operation
- States: IDLE, STREAM, FLUSH, DRAIN.
- IDLE:
  - `s_ready`=0.
  - `i_start` clears col/row/out counters, `o_overrun` and `o_timeout`, then goes to STREAM.
- STREAM:
  - Accept = `s_valid && s_ready`. Each accept forwards `s_data` and advances col.
  - When col wraps at `IMG_WIDTH-1`: row advances and `o_intr` pulses.
  - Accept of the pixel at col=`IMG_WIDTH-1`, row=`IMG_HEIGHT-1` goes to FLUSH.
- FLUSH:
  - Each cycle with `!i_pipe_full` emits one pixel, data 0x00.
  - After `FLUSH_LINES*IMG_WIDTH` pixels, goes to DRAIN.
  - No `o_intr` during flush.
- DRAIN: waits for the output count to reach `OUT_PIXELS`, then pulses `o_frame_done` and goes to IDLE.
- Output counter:
  - Increments on `i_out_valid && i_out_ready` in STREAM, FLUSH and DRAIN.
  - In any state, a handshake when count==`OUT_PIXELS` or in IDLE sets `o_overrun`, and the count does not change.
  - DRAIN exits when the count reaches `OUT_PIXELS`.
- `i_start` while `o_busy` is ignored.
- Counter widths:
  - col: `$clog2(IMG_WIDTH)`
  - row: `$clog2(IMG_HEIGHT)`
  - flush: `$clog2(FLUSH_LINES*IMG_WIDTH+1)`
  - out: `$clog2(OUT_PIXELS+1)`
  - No counter wraps except col.
- Reset, including mid-frame:
  - State goes to IDLE.
  - All counters go to 0.
  - Every output goes to 0: `s_ready`, `o_pix_valid`, `o_pix_data`, `o_out_last`, `o_busy`, `o_intr`, `o_frame_done`, `o_overrun`, `o_timeout`.

## Timing
- `s_ready` = (state==STREAM) && `!i_pipe_full`, combinational. Back-pressure takes effect in the same cycle.
- `o_pix_valid` and `o_pix_data` are registered, 1-cycle latency after accept or flush emit. `o_pix_valid` is otherwise 0; data holds its last value.
- `o_intr` is registered, in the cycle after the last pixel of a line is accepted.
- `o_out_last` is combinational: `i_out_valid` && out count==`OUT_PIXELS-1` && state≠IDLE.
- `o_frame_done` is high for 1 cycle, in the cycle after the final output handshake. `o_busy` falls in that same cycle.
- `o_busy` = state≠IDLE, registered.
- A final input accept and an output handshake in the same cycle are both counted.

## Configuration
- `FRAME_TIMEOUT_EN` defined:
  - A watchdog counts consecutive DRAIN cycles with no output handshake.
  - On reaching `TIMEOUT_CYCLES` it sets `o_timeout`, pulses `o_frame_done` and goes to IDLE.
  - The watchdog clears on each handshake.
- `FRAME_TIMEOUT_EN` undefined:
  - No watchdog logic; `o_timeout` is tied 0.
  - DRAIN waits indefinitely.

## Test plan
- W=4, H=4, FLUSH=2, OUT=16, no back-pressure:
  - Start, then 16 pixels 0x01..0x10 → `o_pix_valid` for 16 cycles with matching data, 4 `o_intr` pulses, then 8 pixels of 0x00.
  - 16 output handshakes → `o_out_last` on the 16th; `o_frame_done` and `o_busy`=0 in the next cycle.
- `i_pipe_full` high for 3 cycles at col 2 → `s_ready`=0 in those cycles, no `o_pix_valid`, col holds at 2. Resumes with correct data.
- `s_valid`=1 in IDLE → `s_ready`=0, nothing forwarded. `i_start` in STREAM → ignored, counters unchanged.
- Extra output handshake after `o_frame_done` → `o_overrun`=1 and stays high; the next `i_start` clears it.
- `i_rst` asserted mid-STREAM at row 2 → all outputs 0 immediately. The next frame produces exactly 4 `o_intr` pulses and 16 counted outputs.
- With `FRAME_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: outputs stall in DRAIN → `o_timeout`=1 after 8 cycles, `o_frame_done` pulses, state returns to IDLE. Without the macro: stays in DRAIN, `o_timeout`=0.

Source files
------------

// File: rtl/canny_frame_sequencer.sv
// Frame sequencer for the Canny pipeline: input gating, flush-line injection and output tracking.
// Defining FRAME_TIMEOUT_EN adds a drain watchdog that aborts a frame whose output stalls.
module canny_frame_sequencer #(
  parameter int unsigned IMG_WIDTH      = 512,
  parameter int unsigned IMG_HEIGHT     = 512,
  parameter int unsigned FLUSH_LINES    = 10,
  parameter int unsigned OUT_PIXELS     = 262144,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic       o_pix_valid,
  output logic [7:0] o_pix_data,
  input  logic       i_pipe_full,
  input  logic       i_out_valid,
  input  logic       i_out_ready,
  output logic       o_out_last,
  output logic       o_busy,
  output logic       o_intr,
  output logic       o_frame_done,
  output logic       o_overrun,
  output logic       o_timeout
);

  localparam int unsigned FlushTotal = FLUSH_LINES * IMG_WIDTH;
  localparam int unsigned ColW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned FlushW = (FlushTotal > 0) ? $clog2(FlushTotal + 1) : 1;
  localparam int unsigned OutW   = (OUT_PIXELS > 0) ? $clog2(OUT_PIXELS + 1) : 1;

  localparam logic [ColW-1:0]   ColLast   = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0]   RowLast   = RowW'(IMG_HEIGHT - 1);
  localparam logic [FlushW-1:0] FlushLast = FlushW'(FlushTotal - 1);
  localparam logic [OutW-1:0]   OutFull   = OutW'(OUT_PIXELS);
  localparam logic [OutW-1:0]   OutLast   = OutW'(OUT_PIXELS - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStream = 2'd1;
  localparam logic [1:0] StFlush  = 2'd2;
  localparam logic [1:0] StDrain  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [FlushW-1:0] flush_q, flush_d;
  logic [OutW-1:0]   out_q, out_d;
  logic              pix_valid_q, pix_valid_d;
  logic [7:0]        pix_data_q, pix_data_d;
  logic              intr_q, intr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;

  logic accept, flush_emit, out_hs, out_full, col_last, row_last;

  assign s_ready    = (state_q == StStream) && !i_pipe_full;
  assign accept     = s_valid && s_ready;
  assign flush_emit = (state_q == StFlush) && !i_pipe_full;
  assign out_hs     = i_out_valid && i_out_ready;
  assign out_full   = (out_q == OutFull);
  assign col_last   = (col_q == ColLast);
  assign row_last   = (row_q == RowLast);
  assign o_out_last = i_out_valid && (out_q == OutLast) && (state_q != StIdle);

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned WdW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYCLES - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    flush_d     = flush_q;
    out_d       = out_q;
    pix_valid_d = 1'b0;
    pix_data_d  = pix_data_q;
    intr_d      = 1'b0;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
`ifdef FRAME_TIMEOUT_EN
    wd_d        = '0;
    timeout_d   = timeout_q;
`endif

    // Output beats are tracked independently of the input side; a beat with no room is an overrun.
    if (out_hs) begin
      if ((state_q == StIdle) || out_full) begin
        overrun_d = 1'b1;
      end else begin
        out_d = out_q + 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (i_start) begin
          col_d     = '0;
          row_d     = '0;
          flush_d   = '0;
          out_d     = '0;
          overrun_d = 1'b0;
`ifdef FRAME_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d   = StStream;
        end
      end
      StStream: begin
        if (accept) begin
          pix_valid_d = 1'b1;
          pix_data_d  = s_data;
          if (col_last) begin
            col_d  = '0;
            intr_d = 1'b1;
            if (row_last) begin
              state_d = (FlushTotal == 0) ? StDrain : StFlush;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      StFlush: begin
        if (flush_emit) begin
          pix_valid_d = 1'b1;
          pix_data_d  = 8'h00;
          flush_d     = flush_q + 1'b1;
          if (flush_q == FlushLast) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (out_d == OutFull) begin
          done_d  = 1'b1;
          state_d = StIdle;
`ifdef FRAME_TIMEOUT_EN
        end else if (!out_hs) begin
          if (wd_q == WdLast) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = StIdle;
          end else begin
            wd_d = wd_q + 1'b1;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      col_q       <= '0;
      row_q       <= '0;
      flush_q     <= '0;
      out_q       <= '0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= 8'h00;
      intr_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      flush_q     <= flush_d;
      out_q       <= out_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
      intr_q      <= intr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef FRAME_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_pix_valid  = pix_valid_q;
  assign o_pix_data   = pix_data_q;
  assign o_intr       = intr_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_overrun    = overrun_q;

endmodule
